// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned 8x8 multiply (shift-add) and 8/8 divide (restoring)
// sequencer. It borrows the shared ALU while busy, using only ADD and SUB
// plus the carry/borrow flag, and runs one iteration per RUN cycle.
module alu_muldiv_seq #(
    parameter logic [3:0] SEL_ADD = 4'd0,
    parameter logic [3:0] SEL_SUB = 4'd1,
    parameter int         ITER    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       op,
    input  logic [7:0] opnd_a,
    input  logic [7:0] opnd_b,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero,
    output logic [7:0] result_hi,
    output logic [7:0] result_lo,
    output logic       alu_req,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [7:0] alu_result,
    input  logic [3:0] alu_nzvc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAST_ITER = 3'(ITER - 1);

    state_t     state_q,  state_d;
    logic [2:0] cnt_q,    cnt_d;
    logic       op_q,     op_d;       // 0 = MUL, 1 = DIV
    logic [7:0] opnd_q,   opnd_d;     // multiplicand (MUL) or divisor (DIV)
    logic [7:0] hi_q,     hi_d;       // partial product high / remainder
    logic [7:0] lo_q,     lo_d;       // multiplier bits / quotient
    logic [7:0] res_hi_q, res_hi_d;
    logic [7:0] res_lo_q, res_lo_d;
    logic       dbz_q,    dbz_d;

    // Intermediate iteration values
    logic       carry;
    logic       div_msb;
    logic [7:0] div_r;
    logic [7:0] div_q;
    logic [7:0] iter_hi;
    logic [7:0] iter_lo;

    // Only the carry/borrow flag matters; the other flags are deliberately dropped.
    logic unused_nzvc;
    assign unused_nzvc = ^alu_nzvc[3:1];

    // State and datapath registers; reset aborts any run without a done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            op_q     <= 1'b0;
            opnd_q   <= 8'd0;
            hi_q     <= 8'd0;
            lo_q     <= 8'd0;
            res_hi_q <= 8'd0;
            res_lo_q <= 8'd0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dbz_q    <= dbz_d;
        end
    end

    // Next-state, iteration datapath and ALU drive.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dbz_d    = dbz_q;
        alu_a    = 8'd0;
        alu_b    = 8'd0;
        alu_sel  = SEL_ADD;
        carry    = alu_nzvc[0];
        // Divide pre-shift sits combinationally ahead of the ALU.
        div_msb  = hi_q[7];
        div_r    = {hi_q[6:0], lo_q[7]};
        div_q    = {lo_q[6:0], 1'b0};
        iter_hi  = hi_q;
        iter_lo  = lo_q;

        case (state_q)
            ST_RUN: begin
                alu_b = opnd_q;
                if (!op_q) begin
                    alu_sel = SEL_ADD;
                    alu_a   = hi_q;
                    if (lo_q[0]) begin
                        iter_hi = {carry, alu_result[7:1]};
                        iter_lo = {alu_result[0], lo_q[7:1]};
                    end else begin
                        iter_hi = {1'b0, hi_q[7:1]};
                        iter_lo = {hi_q[0], lo_q[7:1]};
                    end
                end else begin
                    alu_sel = SEL_SUB;
                    alu_a   = div_r;
                    // Borrow flag set means r' < divisor, unless the shifted-out
                    // bit makes the true 9-bit remainder large enough anyway.
                    if (div_msb || !carry) begin
                        iter_hi = alu_result;
                        iter_lo = div_q | 8'd1;
                    end else begin
                        iter_hi = div_r;
                        iter_lo = div_q;
                    end
                end
                hi_d  = iter_hi;
                lo_d  = iter_lo;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d  = ST_DONE;
                    res_hi_d = iter_hi;
                    res_lo_d = iter_lo;
                end
            end

            default: begin
                // IDLE and DONE both accept a new request.
                if (start) begin
                    op_d   = op;
                    dbz_d  = 1'b0;
                    cnt_d  = 3'd0;
                    hi_d   = 8'd0;
                    opnd_d = op ? opnd_b : opnd_a;
                    lo_d   = op ? opnd_a : opnd_b;
                    if (op && (opnd_b == 8'd0)) begin
                        state_d  = ST_DONE;
                        dbz_d    = 1'b1;
                        res_hi_d = opnd_a;
                        res_lo_d = 8'hFF;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign alu_req     = busy;
    assign div_by_zero = dbz_q;
    assign result_hi   = res_hi_q;
    assign result_lo   = res_lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed-vector bench for alu_muldiv_seq with a behavioural ALU model.
module tb_alu_muldiv_seq;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       op;
    logic [7:0] opnd_a;
    logic [7:0] opnd_b;
    logic       busy;
    logic       done;
    logic       div_by_zero;
    logic [7:0] result_hi;
    logic [7:0] result_lo;
    logic       alu_req;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_result;
    logic [3:0] alu_nzvc;

    int tests_run = 0;
    int tests_failed = 0;

    alu_muldiv_seq dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .opnd_a      (opnd_a),
        .opnd_b      (opnd_b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .result_hi   (result_hi),
        .result_lo   (result_lo),
        .alu_req     (alu_req),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_result  (alu_result),
        .alu_nzvc    (alu_nzvc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU model: ADD gives carry-out, SUB gives borrow in NZVC[0].
    always_comb begin
        logic [8:0] wide;
        wide = 9'd0;
        if (alu_sel == 4'd1) begin
            wide = {1'b0, alu_a} - {1'b0, alu_b};
            wide[8] = (alu_a < alu_b);
        end else begin
            wide = {1'b0, alu_a} + {1'b0, alu_b};
        end
        alu_result = wide[7:0];
        alu_nzvc   = {wide[7], (wide[7:0] == 8'd0), 1'b0, wide[8]};
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a one-cycle start; returns 1 time unit after the accept edge.
    task automatic issue(input logic o, input logic [7:0] a, input logic [7:0] b);
        start  = 1'b1;
        op     = o;
        opnd_a = a;
        opnd_b = b;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    // Follow a transaction to done; optionally poke start during RUN.
    task automatic wait_done(input string tag, input logic [7:0] exp_hi, input logic [7:0] exp_lo,
                             input logic exp_dbz, input int exp_lat, input bit poke);
        int lat;
        int busy_cnt;
        bit got;
        lat = 0;
        busy_cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (poke && lat == 3) begin
                start = 1'b1; op = 1'b1; opnd_a = 8'd99; opnd_b = 8'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({tag, " done_seen"}, 16'(got), 16'd1);
        check({tag, " latency"}, 16'(lat), 16'(exp_lat));
        check({tag, " busy_cycles"}, 16'(busy_cnt), 16'(exp_lat));
        check({tag, " result"}, {result_hi, result_lo}, {exp_hi, exp_lo});
        check({tag, " div_by_zero"}, 16'(div_by_zero), 16'(exp_dbz));
        check({tag, " alu_idle"}, {4'(alu_req), alu_sel, alu_a}, 16'h0000);
        $display("[TB] %s -> hi=%02h lo=%02h dbz=%0d lat=%0d", tag, result_hi, result_lo, div_by_zero, lat);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 1'b0;
        opnd_a  = 8'd0;
        opnd_b  = 8'd0;
        #12;
        check("reset outputs", {busy, done, div_by_zero, alu_req, alu_sel, result_hi}, 16'h0000);
        check("reset result_lo", {result_lo, alu_a}, 16'h0000);
        reset_n = 1'b1;
        @(posedge clk); #1;

        issue(1'b0, 8'd13, 8'd11);   wait_done("MUL 13*11", 8'h00, 8'h8F, 1'b0, 8, 1'b0);
        @(posedge clk); #1;
        check("done pulse one cycle", 16'(done), 16'd0);
        issue(1'b0, 8'd255, 8'd255); wait_done("MUL 255*255", 8'hFE, 8'h01, 1'b0, 8, 1'b0);
        @(posedge clk); #1;
        issue(1'b0, 8'd0, 8'd200);   wait_done("MUL 0*200", 8'h00, 8'h00, 1'b0, 8, 1'b0);
        @(posedge clk); #1;
        issue(1'b1, 8'd200, 8'd7);   wait_done("DIV 200/7", 8'h04, 8'h1C, 1'b0, 8, 1'b0);
        @(posedge clk); #1;
        issue(1'b1, 8'd255, 8'd128); wait_done("DIV 255/128", 8'h7F, 8'h01, 1'b0, 8, 1'b0);
        @(posedge clk); #1;
        issue(1'b1, 8'd255, 8'd1);   wait_done("DIV 255/1", 8'h00, 8'hFF, 1'b0, 8, 1'b0);
        @(posedge clk); #1;
        issue(1'b1, 8'd7, 8'd0);     wait_done("DIV 7/0", 8'h07, 8'hFF, 1'b1, 0, 1'b0);
        @(posedge clk); #1;
        check("dbz held after done", 16'(div_by_zero), 16'd1);

        // start pulsed mid-run must be dropped
        issue(1'b0, 8'd13, 8'd11);   wait_done("MUL 13*11 poked", 8'h00, 8'h8F, 1'b0, 8, 1'b1);
        @(posedge clk); #1;
        check("poke not queued", {15'd0, busy}, 16'd0);

        // back-to-back: new start presented while in DONE
        issue(1'b1, 8'd200, 8'd7);   wait_done("DIV 200/7 b2b-1", 8'h04, 8'h1C, 1'b0, 8, 1'b0);
        issue(1'b0, 8'd255, 8'd255);
        check("b2b results held in RUN", {result_hi, result_lo}, 16'h041C);
        wait_done("MUL 255*255 b2b-2", 8'hFE, 8'h01, 1'b0, 8, 1'b0);
        @(posedge clk); #1;

        // asynchronous reset during iteration 4
        issue(1'b0, 8'd200, 8'd200);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset flags", {busy, done, div_by_zero, alu_req, alu_sel, 8'h00}, 16'h0000);
        check("async reset result", {result_hi, result_lo}, 16'h0000);
        check("async reset alu ops", {alu_a, alu_b}, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("no done under reset", {15'd0, done}, 16'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle after reset", {14'd0, busy, done}, 16'd0);
        issue(1'b0, 8'd3, 8'd5);     wait_done("MUL 3*5 after reset", 8'h00, 8'h0F, 1'b0, 8, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
